// File: rtl/tdc_comma_aligner.sv
// Comma-based word aligner for the TDC serial link: searches all ten bit offsets
// of the deserialized stream, locks with hysteresis and emits aligned abcdeifghj symbols.
module tdc_comma_aligner #(
  parameter int unsigned pLockCommas    = 3,
  parameter int unsigned pUnlockCommas  = 2,
  parameter int unsigned pVerifyTimeout = 1023
) (
  input  logic       i_Clk,
  input  logic       i_ARst_L,
  input  logic       soft_reset_i,
  input  logic       i_enable,
  input  logic [9:0] i10_Raw,
  output logic [9:0] o10_Dout,
  output logic       o_Valid,
  output logic       o_Comma,
  output logic       o_Locked,
  output logic [3:0] o4_Shift
);

  localparam int unsigned W    = 10;
  localparam int unsigned NOFF = 10;
  localparam int unsigned SW   = 4;
  localparam int unsigned CW   = 10;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t          state, state_d;
  logic [W-1:0]    prev;
  logic            primed;
  logic [SW-1:0]   shift, shift_d;
  logic [CW-1:0]   cnt, cnt_d, cnt_inc;
  logic [W-1:0]    dout_d;
  logic            comma_d;

  logic [2*W-1:0]  w20;
  logic [W-1:0]    cand [NOFF];
  logic [NOFF-1:0] comma_vec;
  logic            any_comma, at_shift, other_comma;
  logic [SW-1:0]   low_any, low_other;

  assign w20       = {prev, i10_Raw};
  assign any_comma = |comma_vec;
  assign cnt_inc   = cnt + CW'(1);
  assign o4_Shift  = shift;

  // Candidate extraction and comma test at every offset
  always_comb begin
    for (int k = 0; k < NOFF; k++) begin
      cand[k]      = w20[2*W-1-k -: W];
      comma_vec[k] = (cand[k][9:3] == 7'b0011111) || (cand[k][9:3] == 7'b1100000);
    end
  end

  // Lowest comma offset overall and lowest one away from the current shift
  always_comb begin
    low_any     = '0;
    low_other   = '0;
    at_shift    = 1'b0;
    other_comma = 1'b0;
    for (int k = NOFF - 1; k >= 0; k--) begin
      if (comma_vec[k]) begin
        low_any = SW'(k);
        if (SW'(k) == shift) begin
          at_shift = 1'b1;
        end else begin
          low_other   = SW'(k);
          other_comma = 1'b1;
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    shift_d = shift;
    cnt_d   = cnt;
    unique case (state)
      HUNT: begin
        if (any_comma) begin
          shift_d = low_any;
          if (pLockCommas == 1) begin
            state_d = LOCKED;
            cnt_d   = '0;
          end else begin
            state_d = VERIFY;
            cnt_d   = CW'(1);
          end
        end
      end
      VERIFY: begin
        if (at_shift) begin
          if (cnt_inc >= CW'(pLockCommas)) begin
            state_d = LOCKED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (other_comma) begin
          shift_d = low_other;
          cnt_d   = CW'(1);
        end else if (cnt_inc >= CW'(pVerifyTimeout)) begin
          state_d = HUNT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      LOCKED: begin
        if (at_shift) begin
          cnt_d = '0;
        end else if (other_comma) begin
          if (cnt_inc >= CW'(pUnlockCommas)) begin
            state_d = HUNT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = HUNT;
        cnt_d   = '0;
      end
    endcase
  end

  // Output symbol follows the offset chosen by this word's update
  always_comb begin
    dout_d  = '0;
    comma_d = 1'b0;
    for (int k = 0; k < NOFF; k++) begin
      if (SW'(k) == shift_d) begin
        dout_d  = cand[k];
        comma_d = comma_vec[k];
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_ARst_L) begin
    if (!i_ARst_L) begin
      state    <= HUNT;
      prev     <= '0;
      primed   <= 1'b0;
      shift    <= '0;
      cnt      <= '0;
      o10_Dout <= '0;
      o_Valid  <= 1'b0;
      o_Comma  <= 1'b0;
      o_Locked <= 1'b0;
    end else if (soft_reset_i) begin
      state    <= HUNT;
      prev     <= '0;
      primed   <= 1'b0;
      shift    <= '0;
      cnt      <= '0;
      o10_Dout <= '0;
      o_Valid  <= 1'b0;
      o_Comma  <= 1'b0;
      o_Locked <= 1'b0;
    end else begin
      o_Valid <= 1'b0;
      if (i_enable) begin
        prev   <= i10_Raw;
        primed <= 1'b1;
        if (primed) begin
          state    <= state_d;
          shift    <= shift_d;
          cnt      <= cnt_d;
          o10_Dout <= dout_d;
          o_Comma  <= comma_d;
          o_Valid  <= 1'b1;
          o_Locked <= (state_d == LOCKED);
        end
      end
    end
  end

endmodule
